// File: rtl/axil_decoder.sv
// axil_decoder: AXI-Lite 1:N address decoder with independent single-outstanding read and write paths.
module axil_decoder #(
  parameter int N_SLAVES = 2,
  parameter int WIN_W    = 8,
  parameter int ADDR_W   = 32
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  input  logic [ADDR_W-1:0]                s_awaddr,
  input  logic [2:0]                       s_awprot,
  input  logic                             s_awvalid,
  output logic                             s_awready,
  input  logic [31:0]                      s_wdata,
  input  logic [3:0]                       s_wstrb,
  input  logic                             s_wvalid,
  output logic                             s_wready,
  output logic [1:0]                       s_bresp,
  output logic                             s_bvalid,
  input  logic                             s_bready,
  input  logic [ADDR_W-1:0]                s_araddr,
  input  logic [2:0]                       s_arprot,
  input  logic                             s_arvalid,
  output logic                             s_arready,
  output logic [31:0]                      s_rdata,
  output logic [1:0]                       s_rresp,
  output logic                             s_rvalid,
  input  logic                             s_rready,
  output logic [N_SLAVES-1:0][ADDR_W-1:0]  m_awaddr,
  output logic [N_SLAVES-1:0][2:0]         m_awprot,
  output logic [N_SLAVES-1:0]              m_awvalid,
  input  logic [N_SLAVES-1:0]              m_awready,
  output logic [N_SLAVES-1:0][31:0]        m_wdata,
  output logic [N_SLAVES-1:0][3:0]         m_wstrb,
  output logic [N_SLAVES-1:0]              m_wvalid,
  input  logic [N_SLAVES-1:0]              m_wready,
  input  logic [N_SLAVES-1:0][1:0]         m_bresp,
  input  logic [N_SLAVES-1:0]              m_bvalid,
  output logic [N_SLAVES-1:0]              m_bready,
  output logic [N_SLAVES-1:0][ADDR_W-1:0]  m_araddr,
  output logic [N_SLAVES-1:0][2:0]         m_arprot,
  output logic [N_SLAVES-1:0]              m_arvalid,
  input  logic [N_SLAVES-1:0]              m_arready,
  input  logic [N_SLAVES-1:0][31:0]        m_rdata,
  input  logic [N_SLAVES-1:0][1:0]         m_rresp,
  input  logic [N_SLAVES-1:0]              m_rvalid,
  output logic [N_SLAVES-1:0]              m_rready
);
  localparam int IW = N_SLAVES > 1 ? $clog2(N_SLAVES) : 1;
  localparam logic [ADDR_W-1:0] WMASK = {ADDR_W{1'b1}} >> (ADDR_W - WIN_W);
  if (ADDR_W < WIN_W + $clog2(N_SLAVES)) begin : g_bad_addr_w
    $error("axil_decoder: ADDR_W too small for WIN_W and N_SLAVES");
  end
  // Everything above the window offset, read as one number, must be a valid slave index.
  function automatic logic mapped(input logic [ADDR_W-1:0] a);
    return (a >> WIN_W) < ADDR_W'(N_SLAVES);
  endfunction
  function automatic logic [IW-1:0] idx_of(input logic [ADDR_W-1:0] a);
    return IW'(a >> WIN_W);
  endfunction
  function automatic logic [N_SLAVES-1:0] oh(input logic [IW-1:0] i);
    return N_SLAVES'(1) << i;
  endfunction
  typedef enum logic [1:0] {W_IDLE, W_FWD, W_WAITB, W_RESP} wst_t;
  typedef enum logic [1:0] {R_IDLE, R_FWD, R_WAITR, R_RESP} rst_t;
  wst_t wst;
  rst_t rst;
  logic got_aw, got_w, w_map;
  logic [IW-1:0] widx, ridx;
  logic [ADDR_W-1:0] aw_addr, ar_addr;
  logic [2:0] aw_prot, ar_prot;
  logic [31:0] w_data;
  logic [3:0] w_strb;
  logic aw_fire, w_fire, ar_fire, aw_have, w_have, cur_wmap;
  logic [IW-1:0] cur_widx;
  assign aw_fire  = s_awvalid & s_awready;
  assign w_fire   = s_wvalid & s_wready;
  assign ar_fire  = s_arvalid & s_arready;
  assign aw_have  = got_aw | aw_fire;
  assign w_have   = got_w | w_fire;
  assign cur_wmap = aw_fire ? mapped(s_awaddr) : w_map;
  assign cur_widx = aw_fire ? idx_of(s_awaddr) : widx;
  // Payload is broadcast; only the selected port ever sees a valid.
  always_comb begin
    for (int i = 0; i < N_SLAVES; i++) begin
      m_awaddr[i] = aw_addr;
      m_awprot[i] = aw_prot;
      m_wdata[i]  = w_data;
      m_wstrb[i]  = w_strb;
      m_araddr[i] = ar_addr;
      m_arprot[i] = ar_prot;
    end
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wst       <= W_IDLE;
      got_aw    <= 1'b0;
      got_w     <= 1'b0;
      w_map     <= 1'b0;
      widx      <= '0;
      aw_addr   <= '0;
      aw_prot   <= '0;
      w_data    <= '0;
      w_strb    <= '0;
      s_awready <= 1'b0;
      s_wready  <= 1'b0;
      s_bvalid  <= 1'b0;
      s_bresp   <= '0;
      m_awvalid <= '0;
      m_wvalid  <= '0;
      m_bready  <= '0;
    end else begin
      case (wst)
        W_IDLE: begin
          if (aw_fire) begin
            aw_addr <= s_awaddr & WMASK;
            aw_prot <= s_awprot;
            w_map   <= mapped(s_awaddr);
            widx    <= idx_of(s_awaddr);
          end
          if (w_fire) begin
            w_data <= s_wdata;
            w_strb <= s_wstrb;
          end
          if (aw_have && w_have) begin
            got_aw    <= 1'b0;
            got_w     <= 1'b0;
            s_awready <= 1'b0;
            s_wready  <= 1'b0;
            if (cur_wmap) begin
              m_awvalid <= oh(cur_widx);
              m_wvalid  <= oh(cur_widx);
              wst       <= W_FWD;
            end else begin
              s_bresp  <= 2'b11;
              s_bvalid <= 1'b1;
              wst      <= W_RESP;
            end
          end else begin
            got_aw    <= aw_have;
            got_w     <= w_have;
            s_awready <= !aw_have;
            s_wready  <= !w_have;
          end
        end
        W_FWD: begin
          m_awvalid <= m_awvalid & ~m_awready;
          m_wvalid  <= m_wvalid & ~m_wready;
          if (!(|(m_awvalid & ~m_awready)) && !(|(m_wvalid & ~m_wready))) begin
            m_bready <= oh(widx);
            wst      <= W_WAITB;
          end
        end
        W_WAITB: if (|(m_bready & m_bvalid)) begin
          s_bresp  <= m_bresp[widx];
          s_bvalid <= 1'b1;
          m_bready <= '0;
          wst      <= W_RESP;
        end
        W_RESP: if (s_bready) begin
          s_bvalid  <= 1'b0;
          s_awready <= 1'b1;
          s_wready  <= 1'b1;
          wst       <= W_IDLE;
        end
        default: wst <= W_IDLE;
      endcase
    end
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rst       <= R_IDLE;
      ridx      <= '0;
      ar_addr   <= '0;
      ar_prot   <= '0;
      s_arready <= 1'b0;
      s_rvalid  <= 1'b0;
      s_rdata   <= '0;
      s_rresp   <= '0;
      m_arvalid <= '0;
      m_rready  <= '0;
    end else begin
      case (rst)
        R_IDLE: begin
          s_arready <= !ar_fire;
          if (ar_fire) begin
            ar_addr <= s_araddr & WMASK;
            ar_prot <= s_arprot;
            ridx    <= idx_of(s_araddr);
            if (mapped(s_araddr)) begin
              m_arvalid <= oh(idx_of(s_araddr));
              rst       <= R_FWD;
            end else begin
              s_rdata  <= '0;
              s_rresp  <= 2'b11;
              s_rvalid <= 1'b1;
              rst      <= R_RESP;
            end
          end
        end
        R_FWD: if (|(m_arvalid & m_arready)) begin
          m_arvalid <= '0;
          m_rready  <= oh(ridx);
          rst       <= R_WAITR;
        end
        R_WAITR: if (|(m_rready & m_rvalid)) begin
          s_rdata  <= m_rdata[ridx];
          s_rresp  <= m_rresp[ridx];
          s_rvalid <= 1'b1;
          m_rready <= '0;
          rst      <= R_RESP;
        end
        R_RESP: if (s_rready) begin
          s_rvalid  <= 1'b0;
          s_arready <= 1'b1;
          rst       <= R_IDLE;
        end
        default: rst <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axil_decoder.sv
// tb_axil_decoder: directed bench for axil_decoder with a delay-configurable slave model per port.
module tb_axil_decoder;
  localparam int N = 2;
  logic aclk = 1'b0, aresetn = 1'b0;
  logic [31:0] s_awaddr = '0, s_wdata = '0, s_araddr = '0, s_rdata;
  logic [2:0] s_awprot = '0, s_arprot = '0;
  logic [3:0] s_wstrb = '0;
  logic s_awvalid = 1'b0, s_wvalid = 1'b0, s_bready = 1'b0, s_arvalid = 1'b0, s_rready = 1'b0;
  logic s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [1:0] s_bresp, s_rresp;
  logic [N-1:0][31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [N-1:0][2:0] m_awprot, m_arprot;
  logic [N-1:0][3:0] m_wstrb;
  logic [N-1:0][1:0] m_bresp, m_rresp;
  logic [N-1:0] m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [N-1:0] m_arvalid, m_arready, m_rvalid, m_rready;
  int total = 0, bad = 0, tmo = 0, bhs = 0;
  int aw_dly[N], w_dly[N], ar_dly[N], b_dly[N], r_dly[N];
  int aw_wait[N], w_wait[N], ar_wait[N], b_wait[N], r_wait[N];
  int vcnt[N], aw_hs[N];
  logic got_aw[N], got_w[N], got_ar[N];
  logic [N-1:0] bv, rv;
  logic [31:0] aw_seen[N], w_seen[N], ar_seen[N], rd_data[N];
  logic [3:0] strb_seen[N];
  logic [1:0] bresp_v[N], rresp_v[N];
  axil_decoder #(.N_SLAVES(N), .WIN_W(8), .ADDR_W(32)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_awaddr(s_awaddr), .s_awprot(s_awprot), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );
  always #5 aclk = ~aclk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  always @(posedge aclk) if (s_bvalid && s_bready) bhs++;
  assign m_bvalid = bv;
  assign m_rvalid = rv;
  always_comb begin
    for (int i = 0; i < N; i++) begin
      m_awready[i] = aw_wait[i] >= aw_dly[i];
      m_wready[i]  = w_wait[i] >= w_dly[i];
      m_arready[i] = ar_wait[i] >= ar_dly[i];
      m_bresp[i]   = bresp_v[i];
      m_rresp[i]   = rresp_v[i];
      m_rdata[i]   = rd_data[i];
    end
  end
  // Slave model: readies held off by *_dly cycles of valid, responses issued *_dly cycles after request.
  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      bv <= '0;
      rv <= '0;
      for (int i = 0; i < N; i++) begin
        aw_wait[i] <= 0; w_wait[i] <= 0; ar_wait[i] <= 0; b_wait[i] <= 0; r_wait[i] <= 0;
        got_aw[i] <= 1'b0; got_w[i] <= 1'b0; got_ar[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (m_awvalid[i] || m_wvalid[i] || m_arvalid[i]) vcnt[i] <= vcnt[i] + 1;
        if (m_awvalid[i] && m_awready[i]) begin
          got_aw[i] <= 1'b1; aw_seen[i] <= m_awaddr[i]; aw_hs[i] <= aw_hs[i] + 1; aw_wait[i] <= 0;
        end else if (m_awvalid[i]) aw_wait[i] <= aw_wait[i] + 1;
        if (m_wvalid[i] && m_wready[i]) begin
          got_w[i] <= 1'b1; w_seen[i] <= m_wdata[i]; strb_seen[i] <= m_wstrb[i]; w_wait[i] <= 0;
        end else if (m_wvalid[i]) w_wait[i] <= w_wait[i] + 1;
        if (bv[i] && m_bready[i]) bv[i] <= 1'b0;
        else if (got_aw[i] && got_w[i] && !bv[i]) begin
          if (b_wait[i] >= b_dly[i]) begin
            bv[i] <= 1'b1; got_aw[i] <= 1'b0; got_w[i] <= 1'b0; b_wait[i] <= 0;
          end else b_wait[i] <= b_wait[i] + 1;
        end
        if (m_arvalid[i] && m_arready[i]) begin
          got_ar[i] <= 1'b1; ar_seen[i] <= m_araddr[i]; ar_wait[i] <= 0;
        end else if (m_arvalid[i]) ar_wait[i] <= ar_wait[i] + 1;
        if (rv[i] && m_rready[i]) rv[i] <= 1'b0;
        else if (got_ar[i] && !rv[i]) begin
          if (r_wait[i] >= r_dly[i]) begin
            rv[i] <= 1'b1; got_ar[i] <= 1'b0; r_wait[i] <= 0;
          end else r_wait[i] <= r_wait[i] + 1;
        end
      end
    end
  end
  task automatic send_aw(input logic [31:0] a);
    s_awaddr = a; s_awvalid = 1'b1;
    for (int n = 0; n < 60; n++) begin
      @(posedge aclk);
      if (s_awready) begin #1 s_awvalid = 1'b0; return; end
    end
    tmo++; #1 s_awvalid = 1'b0;
  endtask
  task automatic send_w(input logic [31:0] d, input logic [3:0] st);
    s_wdata = d; s_wstrb = st; s_wvalid = 1'b1;
    for (int n = 0; n < 60; n++) begin
      @(posedge aclk);
      if (s_wready) begin #1 s_wvalid = 1'b0; return; end
    end
    tmo++; #1 s_wvalid = 1'b0;
  endtask
  task automatic send_ar(input logic [31:0] a);
    s_araddr = a; s_arvalid = 1'b1;
    for (int n = 0; n < 60; n++) begin
      @(posedge aclk);
      if (s_arready) begin #1 s_arvalid = 1'b0; return; end
    end
    tmo++; #1 s_arvalid = 1'b0;
  endtask
  task automatic wait_b(output logic [1:0] r, output int c);
    s_bready = 1'b1; r = 2'bxx; c = 0;
    for (int n = 0; n < 60; n++) begin
      @(posedge aclk); c++;
      if (s_bvalid) begin r = s_bresp; #1 s_bready = 1'b0; return; end
    end
    tmo++; #1 s_bready = 1'b0;
  endtask
  task automatic wait_r(output logic [31:0] d, output logic [1:0] r, output int c);
    s_rready = 1'b1; d = 'x; r = 2'bxx; c = 0;
    for (int n = 0; n < 60; n++) begin
      @(posedge aclk); c++;
      if (s_rvalid) begin d = s_rdata; r = s_rresp; #1 s_rready = 1'b0; return; end
    end
    tmo++; #1 s_rready = 1'b0;
  endtask
  task automatic check_tmo(input string name);
    total++;
    if (tmo !== 0) begin bad++; $display("FAIL %s_timeout: got %0d expired waits want 0", name, tmo); end
    tmo = 0;
  endtask
  function automatic logic [14:0] ctl();
    return {s_awready, s_wready, s_bvalid, s_arready, s_rvalid, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready};
  endfunction
  task automatic test_reset();
    repeat (3) @(posedge aclk);
    #1;
    total++;
    if (ctl() !== 15'h0) begin bad++; $display("FAIL rst_ctl: got %h want 0", ctl()); end
    total++;
    if ({s_rdata, s_rresp, s_bresp} !== 36'h0) begin bad++; $display("FAIL rst_data: got %h want 0", {s_rdata, s_rresp, s_bresp}); end
    aresetn = 1'b1;
    @(posedge aclk); #1;
    total++;
    if ({s_awready, s_wready, s_arready, s_bvalid, s_rvalid} !== 5'b11100) begin
      bad++; $display("FAIL rst_ready: got %b want 11100", {s_awready, s_wready, s_arready, s_bvalid, s_rvalid});
    end
  endtask
  task automatic test_write_map();
    logic [1:0] r; int c, v0, h1;
    v0 = vcnt[0]; h1 = aw_hs[1]; bresp_v[1] = 2'b00;
    fork send_aw(32'h104); send_w(32'hDEADBEEF, 4'hF); join
    total++;
    if ({m_awvalid, m_wvalid} !== 4'b1010) begin bad++; $display("FAIL wr_fwd_valid: got %b want 1010", {m_awvalid, m_wvalid}); end
    wait_b(r, c);
    total++;
    if (r !== 2'b00) begin bad++; $display("FAIL wr_bresp: got %b want 00", r); end
    total++;
    if (aw_seen[1] !== 32'h04) begin bad++; $display("FAIL wr_awaddr: got %h want 00000004", aw_seen[1]); end
    total++;
    if ({w_seen[1], strb_seen[1]} !== {32'hDEADBEEF, 4'hF}) begin bad++; $display("FAIL wr_wdata: got %h/%h want deadbeef/f", w_seen[1], strb_seen[1]); end
    total++;
    if (vcnt[0] - v0 !== 0 || aw_hs[1] - h1 !== 1) begin
      bad++; $display("FAIL wr_routing: got m0 valid cycles %0d m1 aw beats %0d want 0 and 1", vcnt[0] - v0, aw_hs[1] - h1);
    end
    check_tmo("wr");
  endtask
  task automatic test_read_map();
    logic [31:0] d; logic [1:0] r; int tm, ts;
    rd_data[0] = 32'h12345678; rresp_v[0] = 2'b00; tm = -1; ts = -1; d = 'x; r = 2'bxx;
    send_ar(32'h004);
    s_rready = 1'b1;
    for (int t = 0; t < 60; t++) begin
      @(posedge aclk);
      if (tm < 0 && m_rvalid[0] && m_rready[0]) tm = t;
      if (s_rvalid) begin ts = t; d = s_rdata; r = s_rresp; break; end
    end
    #1 s_rready = 1'b0;
    total++;
    if ({d, r} !== {32'h12345678, 2'b00}) begin bad++; $display("FAIL rd_data: got %h/%b want 12345678/00", d, r); end
    total++;
    if (tm < 0 || ts - tm !== 1) begin bad++; $display("FAIL rd_latency: got m_rvalid at %0d s_rvalid at %0d want 1 apart", tm, ts); end
    total++;
    if (ar_seen[0] !== 32'h04) begin bad++; $display("FAIL rd_araddr: got %h want 00000004", ar_seen[0]); end
  endtask
  task automatic test_unmapped();
    logic [31:0] d; logic [1:0] r; int c, v0, v1;
    v0 = vcnt[0]; v1 = vcnt[1]; rd_data[0] = 32'hFFFFFFFF; rd_data[1] = 32'hFFFFFFFF;
    send_ar(32'h200);
    wait_r(d, r, c);
    total++;
    if ({d, r} !== {32'h0, 2'b11}) begin bad++; $display("FAIL unm_rd: got %h/%b want 00000000/11", d, r); end
    total++;
    if (c !== 1) begin bad++; $display("FAIL unm_rd_latency: got %0d want 1", c); end
    fork send_aw(32'h1000); send_w(32'h11111111, 4'hF); join
    wait_b(r, c);
    total++;
    if (r !== 2'b11) begin bad++; $display("FAIL unm_wr: got %b want 11", r); end
    total++;
    if (c !== 1) begin bad++; $display("FAIL unm_wr_latency: got %0d want 1", c); end
    total++;
    if (vcnt[0] !== v0 || vcnt[1] !== v1) begin bad++; $display("FAIL unm_quiet: got m valid cycles %0d/%0d want 0/0", vcnt[0] - v0, vcnt[1] - v1); end
    check_tmo("unm");
  endtask
  task automatic test_w_before_aw();
    logic [1:0] r; int c, hi, b0, h0;
    aw_dly[0] = 4; b_dly[0] = 3; bresp_v[0] = 2'b10; b0 = bhs; h0 = aw_hs[0]; hi = 0;
    send_w(32'hA5A55A5A, 4'h3);
    total++;
    if ({s_wready, s_awready} !== 2'b01) begin bad++; $display("FAIL wfirst_ready: got %b want 01", {s_wready, s_awready}); end
    repeat (3) @(posedge aclk);
    #1 send_aw(32'h010);
    for (int n = 0; n < 60; n++) begin
      @(posedge aclk);
      if (s_bvalid) break;
      if (n == 59) tmo++;
    end
    repeat (4) begin @(posedge aclk); if (s_bvalid && s_bresp === 2'b10) hi++; end
    total++;
    if (hi !== 4) begin bad++; $display("FAIL wfirst_bhold: got %0d cycles want 4", hi); end
    #1 wait_b(r, c);
    total++;
    if (r !== 2'b10 || c !== 1) begin bad++; $display("FAIL wfirst_bresp: got %b after %0d want 10 after 1", r, c); end
    repeat (5) @(posedge aclk);
    total++;
    if (bhs - b0 !== 1 || aw_hs[0] - h0 !== 1) begin bad++; $display("FAIL wfirst_single: got b %0d aw %0d want 1/1", bhs - b0, aw_hs[0] - h0); end
    total++;
    if ({aw_seen[0], w_seen[0], strb_seen[0]} !== {32'h10, 32'hA5A55A5A, 4'h3}) begin
      bad++; $display("FAIL wfirst_data: got %h/%h/%h want 00000010/a5a55a5a/3", aw_seen[0], w_seen[0], strb_seen[0]);
    end
    aw_dly[0] = 0; b_dly[0] = 0; bresp_v[0] = 2'b00;
    #1 check_tmo("wfirst");
  endtask
  task automatic test_back_to_back();
    logic [31:0] d; logic [1:0] r; int c, st;
    rd_data[0] = 32'hCAFEF00D; rresp_v[0] = 2'b00; r_dly[0] = 2; bresp_v[1] = 2'b00; st = 0;
    fork send_ar(32'h008); send_aw(32'h120); send_w(32'h0BADF00D, 4'hF); join
    wait_b(r, c);
    total++;
    if (r !== 2'b00) begin bad++; $display("FAIL conc_bresp: got %b want 00", r); end
    total++;
    if ({aw_seen[1], w_seen[1]} !== {32'h20, 32'h0BADF00D}) begin bad++; $display("FAIL conc_wdata: got %h/%h want 00000020/0badf00d", aw_seen[1], w_seen[1]); end
    for (int n = 0; n < 60; n++) begin
      @(posedge aclk);
      if (s_rvalid) break;
      if (n == 59) tmo++;
    end
    repeat (5) begin @(posedge aclk); if (s_rvalid && s_rdata === 32'hCAFEF00D) st++; end
    total++;
    if (st !== 5) begin bad++; $display("FAIL conc_rstable: got %0d cycles want 5", st); end
    #1 wait_r(d, r, c);
    total++;
    if ({d, r} !== {32'hCAFEF00D, 2'b00} || c !== 1) begin bad++; $display("FAIL conc_rdata: got %h/%b after %0d want cafef00d/00 after 1", d, r, c); end
    r_dly[0] = 0;
    check_tmo("conc");
  endtask
  task automatic test_reset_mid();
    logic [31:0] d; logic [1:0] r; int c;
    b_dly[1] = 30; r_dly[0] = 30;
    fork send_ar(32'h00C); send_aw(32'h140); send_w(32'h77777777, 4'hF); join
    for (int n = 0; n < 60; n++) begin
      @(posedge aclk); #1;
      if (m_bready[1] && m_rready[0]) break;
      if (n == 59) tmo++;
    end
    aresetn = 1'b0;
    #1;
    total++;
    if (ctl() !== 15'h0 || {s_rdata, s_rresp, s_bresp} !== 36'h0) begin bad++; $display("FAIL mid_rst_async: got %h/%h want 0/0", ctl(), {s_rdata, s_rresp, s_bresp}); end
    repeat (2) @(posedge aclk);
    #1;
    total++;
    if (ctl() !== 15'h0) begin bad++; $display("FAIL mid_rst_hold: got %h want 0", ctl()); end
    b_dly[1] = 0; r_dly[0] = 0; rd_data[1] = 32'h600DD00D; rresp_v[1] = 2'b00;
    aresetn = 1'b1;
    @(posedge aclk); #1;
    total++;
    if ({s_awready, s_wready, s_arready, s_bvalid, s_rvalid} !== 5'b11100) begin
      bad++; $display("FAIL mid_rst_ready: got %b want 11100", {s_awready, s_wready, s_arready, s_bvalid, s_rvalid});
    end
    send_ar(32'h1F0);
    wait_r(d, r, c);
    total++;
    if ({d, r, ar_seen[1]} !== {32'h600DD00D, 2'b00, 32'hF0}) begin bad++; $display("FAIL mid_rst_after: got %h/%b/%h want 600dd00d/00/000000f0", d, r, ar_seen[1]); end
    check_tmo("mid_rst");
  endtask
  initial begin
    for (int i = 0; i < N; i++) begin
      aw_dly[i] = 0; w_dly[i] = 0; ar_dly[i] = 0; b_dly[i] = 0; r_dly[i] = 0;
      vcnt[i] = 0; aw_hs[i] = 0; bresp_v[i] = 2'b00; rresp_v[i] = 2'b00; rd_data[i] = '0;
      aw_seen[i] = '0; w_seen[i] = '0; ar_seen[i] = '0; strb_seen[i] = '0;
    end
    test_reset();
    test_write_map();
    test_read_map();
    test_unmapped();
    test_w_before_aw();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
